// File: rtl/escalonador_bombas.sv
// Pump scheduler: shares one motor feed between the lower-tank (m1) and upper-tank (m2)
// pumps with minimum run time, contention time-out, dead time and a latched alarm fault.
module escalonador_bombas #(
   parameter int MIN_ON = 8,
   parameter int MAX_ON = 64,
   parameter int DEAD_T = 4,
   parameter int CW     = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req1,
   input  logic req2,
   input  logic alarme1,
   input  logic alarme2,
   input  logic clr_falha,
   output logic m1,
   output logic m2,
   output logic falha,
   output logic vez
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN1  = 3'd1,
      S_RUN2  = 3'd2,
      S_DEAD  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   localparam logic [CW-1:0] C_MIN_LAST  = CW'(MIN_ON - 1);
   localparam logic [CW-1:0] C_MAX_LAST  = CW'(MAX_ON - 1);
   localparam logic [CW-1:0] C_DEAD_LAST = CW'(DEAD_T - 1);
   localparam logic [CW-1:0] C_CNT_SAT   = {CW{1'b1}};

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic          r_vez;

   logic w_alarm;
   logic w_rel;
   logic w_timeout;
   logic w_dead_done;
   logic w_enter_run1;
   logic w_enter_run2;

   assign w_alarm     = alarme1 | alarme2;
   assign w_rel       = (r_cnt >= C_MIN_LAST);
   assign w_timeout   = (r_cnt >= C_MAX_LAST);
   assign w_dead_done = (r_cnt == C_DEAD_LAST);

   // Next-state decode; an alarm overrides everything, including a pending clear.
   always_comb begin
      w_next = r_state;
      if (w_alarm) begin
         w_next = S_FAULT;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req1 && (!req2 || !r_vez)) begin
                  w_next = S_RUN1;
               end else if (req2) begin
                  w_next = S_RUN2;
               end
            end
            S_RUN1: begin
               if (w_rel && (!req1 || (req2 && w_timeout))) begin
                  w_next = S_DEAD;
               end
            end
            S_RUN2: begin
               if (w_rel && (!req2 || (req1 && w_timeout))) begin
                  w_next = S_DEAD;
               end
            end
            S_DEAD: begin
               if (w_dead_done) begin
                  w_next = S_IDLE;
               end
            end
            S_FAULT: begin
               if (clr_falha) begin
                  w_next = S_IDLE;
               end
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

   assign w_enter_run1 = (w_next == S_RUN1) && (r_state != S_RUN1);
   assign w_enter_run2 = (w_next == S_RUN2) && (r_state != S_RUN2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_vez   <= 1'b0;
      end else begin
         r_state <= w_next;
         // Counter restarts on every state change and saturates instead of wrapping.
         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (r_cnt != C_CNT_SAT) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_enter_run1) begin
            r_vez <= 1'b1;
         end else if (w_enter_run2) begin
            r_vez <= 1'b0;
         end
      end
   end

   assign m1    = (r_state == S_RUN1);
   assign m2    = (r_state == S_RUN2);
   assign falha = (r_state == S_FAULT);
   assign vez   = r_vez;

endmodule

// File: tb/tb_escalonador_bombas.sv
// Bench for escalonador_bombas: directed scenarios plus random req/alarm traffic,
// compared every cycle against a run-length/dead-time reference model.
module tb_escalonador_bombas;

   localparam int MIN_ON = 8;
   localparam int MAX_ON = 64;
   localparam int DEAD_T = 4;
   localparam int CW     = 8;

   logic clk       = 1'b0;
   logic rst_n     = 1'b0;
   logic req1      = 1'b0;
   logic req2      = 1'b0;
   logic alarme1   = 1'b0;
   logic alarme2   = 1'b0;
   logic clr_falha = 1'b0;
   logic m1, m2, falha, vez;

   int n_vec = 0;
   int n_err = 0;

   escalonador_bombas #(
      .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .DEAD_T(DEAD_T), .CW(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req1(req1), .req2(req2),
      .alarme1(alarme1), .alarme2(alarme2), .clr_falha(clr_falha),
      .m1(m1), .m2(m2), .falha(falha), .vez(vez)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: which motor is on (0 none), how long it has been on,
   // remaining dead cycles, fault flag and whose turn it is.
   int mod_on    = 0;
   int mod_len   = 0;
   int mod_dead  = 0;
   bit mod_fault = 1'b0;
   bit mod_turn  = 1'b0;

   task automatic model_reset();
      mod_on = 0; mod_len = 0; mod_dead = 0; mod_fault = 1'b0; mod_turn = 1'b0;
   endtask

   task automatic model_step(input bit r1, input bit r2, input bit a1, input bit a2, input bit clr);
      bit mine, other;
      if (a1 || a2) begin
         mod_fault = 1'b1; mod_on = 0; mod_dead = 0;
      end else if (mod_fault) begin
         if (clr) mod_fault = 1'b0;
      end else if (mod_on != 0) begin
         mine  = (mod_on == 1) ? r1 : r2;
         other = (mod_on == 1) ? r2 : r1;
         if (mod_len >= MIN_ON && (!mine || (other && mod_len >= MAX_ON))) begin
            mod_on = 0; mod_dead = DEAD_T;
         end else begin
            mod_len++;
         end
      end else if (mod_dead > 0) begin
         mod_dead--;
      end else if (r1 && (!r2 || !mod_turn)) begin
         mod_on = 1; mod_len = 1; mod_turn = 1'b1;
      end else if (r2) begin
         mod_on = 2; mod_len = 1; mod_turn = 1'b0;
      end
   endtask

   // Run/gap bookkeeping on the observed motor outputs.
   bit p_m1 = 1'b0, p_m2 = 1'b0, clean = 1'b0;
   int run1 = 0, run2 = 0, last_run1 = 0, last_run2 = 0;
   int gap = 0, last_gap = 0, last_owner = 0;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else model_step(req1, req2, alarme1, alarme2, clr_falha);
         #1;
         check_val("m1",    m1,    32'(mod_on == 1));
         check_val("m2",    m2,    32'(mod_on == 2));
         check_val("falha", falha, 32'(mod_fault));
         check_val("vez",   vez,   32'(mod_turn));
         check_val("excl",  m1 & m2, 0);
         if (m1) begin
            if (!p_m1) begin
               if (last_owner == 2 && clean) check_val("inv_gap", 32'(gap >= DEAD_T + 1), 1);
               last_gap = gap; last_owner = 1; clean = 1'b1; run1 = 0;
            end
            run1++;
         end else if (p_m1) begin
            last_run1 = run1;
            if (rst_n && !falha) check_val("inv_min_on1", 32'(run1 >= MIN_ON), 1);
         end
         if (m2) begin
            if (!p_m2) begin
               if (last_owner == 1 && clean) check_val("inv_gap", 32'(gap >= DEAD_T + 1), 1);
               last_gap = gap; last_owner = 2; clean = 1'b1; run2 = 0;
            end
            run2++;
         end else if (p_m2) begin
            last_run2 = run2;
            if (rst_n && !falha) check_val("inv_min_on2", 32'(run2 >= MIN_ON), 1);
         end
         if (!m1 && !m2) gap++;
         else gap = 0;
         if (falha || !rst_n) clean = 1'b0;
         p_m1 = m1; p_m2 = m2;
      end
   end

   function automatic bit cond(input int sel);
      case (sel)
         0:       return !m1;
         1:       return m1;
         2:       return !m2;
         3:       return m2;
         default: return !m1 && !m2;
      endcase
   endfunction

   task automatic wait_cond(input string tag, input int sel, input int limit);
      int n = 0;
      while (!cond(sel) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, 32'(n < limit), 1);
   endtask

   initial begin
      bit seen2;
      // Reset held with both requests high.
      req1 = 1'b1; req2 = 1'b1;
      #7;
      check_val("rst_m1", m1, 0);
      check_val("rst_m2", m2, 0);
      check_val("rst_falha", falha, 0);
      check_val("rst_vez", vez, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #2;
      check_val("rst_grant_m1", m1, 1);

      // Continuous contention: 64 on, 5 off, alternating.
      wait_cond("wait_m1_off", 0, 200);
      wait_cond("wait_m2_on", 3, 200);
      check_val("cont_run1", last_run1, MAX_ON);
      check_val("cont_gap1", last_gap, DEAD_T + 1);
      check_val("cont_vez0", vez, 0);
      wait_cond("wait_m2_off", 2, 200);
      wait_cond("wait_m1_on", 1, 200);
      check_val("cont_run2", last_run2, MAX_ON);
      check_val("cont_gap2", last_gap, DEAD_T + 1);
      check_val("cont_vez1", vez, 1);

      // Short request: motor still runs MIN_ON cycles, m2 never on.
      req1 = 1'b0; req2 = 1'b0;
      wait_cond("wait_idle", 4, 200);
      repeat (10) @(negedge clk);
      seen2 = 1'b0;
      req1 = 1'b1;
      repeat (3) begin @(negedge clk); seen2 |= m2; end
      req1 = 1'b0;
      repeat (25) begin @(negedge clk); seen2 |= m2; end
      check_val("min_on_len", last_run1, MIN_ON);
      check_val("min_on_no_m2", 32'(seen2), 0);

      // Short request handing over to a waiting pump 2: gap is DEAD_T+1.
      req1 = 1'b1;
      repeat (3) @(negedge clk);
      req1 = 1'b0; req2 = 1'b1;
      wait_cond("wait_m2_hand", 3, 100);
      check_val("hand_run1", last_run1, MIN_ON);
      check_val("hand_gap", last_gap, DEAD_T + 1);

      // Alarm during RUN2 at cnt=10, clear blocked by alarm, then clear and regrant.
      repeat (10) @(negedge clk);
      alarme1 = 1'b1;
      @(negedge clk);
      alarme1 = 1'b0;
      check_val("alarm_m2", m2, 0);
      check_val("alarm_falha", falha, 1);
      alarme1 = 1'b1; clr_falha = 1'b1;
      @(negedge clk);
      check_val("clr_blocked", falha, 1);
      alarme1 = 1'b0; clr_falha = 1'b0;
      @(negedge clk);
      clr_falha = 1'b1; req1 = 1'b1; req2 = 1'b0;
      @(negedge clk);
      clr_falha = 1'b0;
      check_val("clr_falha", falha, 0);
      check_val("clr_no_grant", m1, 0);
      @(negedge clk);
      check_val("clr_regrant", m1, 1);

      // Async reset mid-RUN1 at cnt=20.
      repeat (20) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_val("arst_m1", m1, 0);
      check_val("arst_vez", vez, 0);
      req1 = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #2;
      check_val("arst_idle_m1", m1, 0);
      check_val("arst_idle_vez", vez, 0);

      // Random traffic.
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) == 0) req1 = ~req1;
         if ($urandom_range(0, 9) == 0) req2 = ~req2;
         alarme1   = ($urandom_range(0, 299) == 0);
         alarme2   = ($urandom_range(0, 299) == 0);
         clr_falha = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/escalonador_bombas.md
# escalonador_bombas

Pump scheduler that shares a single motor power feed between the lower-tank pump (m1) and the upper-tank pump (m2) of the two-tank water system. Each per-pump level controller raises a run request and an alarm. This block grants the motors one at a time, enforces minimum run time, maximum run time under contention and a dead time between motors, and latches a fault on any alarm. It sits between the per-pump controllers and the motor drivers.

## Interface
Parameters:
- MIN_ON, 8: minimum cycles a motor stays on once granted (anti-short-cycle); legal ≥1
- MAX_ON, 64: cycles after which a running motor yields if the other pump is requesting; legal ≥MIN_ON
- DEAD_T, 4: cycles both motors are held off after a motor is released; legal ≥1
- CW, 8: counter width; must hold max(MAX_ON, DEAD_T)−1

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- req1  in  1  pump 1 run request
- req2  in  1  pump 2 run request
- alarme1  in  1  pump 1 controller alarm (impossible sensor combination)
- alarme2  in  1  pump 2 controller alarm
- clr_falha  in  1  fault clear request
- m1  out  1  motor 1 enable
- m2  out  1  motor 2 enable
- falha  out  1  fault latched
- vez  out  1  round-robin pointer; 0 = pump 1 has priority, 1 = pump 2

## Operation
- States: IDLE, RUN1, RUN2, DEAD, FAULT. Moore outputs decoded from the registered state: m1 = (RUN1), m2 = (RUN2), falha = (FAULT). m1 and m2 are never high together.
- cnt (CW bits) clears on every state change. Otherwise it increments each cycle and saturates at its maximum; it never wraps.
- Transitions are evaluated at each posedge, in this priority order:
  1. alarme1 | alarme2 → FAULT, from any state including FAULT.
  2. IDLE:
     - only req1 → RUN1
     - only req2 → RUN2
     - both → RUN1 if vez=0, else RUN2
     - neither → stay in IDLE
  3. RUN1: let rel = (cnt ≥ MIN_ON−1).
     - rel & !req1 → DEAD
     - rel & req2 & cnt ≥ MAX_ON−1 → DEAD
     - otherwise stay in RUN1
     - Dropping req1 before MIN_ON does not stop m1.
  4. RUN2: symmetric to RUN1, with req2/req1 swapped.
  5. DEAD: cnt = DEAD_T−1 → IDLE.
  6. FAULT: clr_falha & !alarme1 & !alarme2 → IDLE. Otherwise stay in FAULT. An alarm always wins over a clear.
- vez:
  - set to 1 on entry to RUN1
  - cleared to 0 on entry to RUN2
  - unchanged otherwise, including through FAULT
- With no contention, a lone requester is served regardless of vez.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, cnt = 0, m1 = m2 = falha = 0, vez = 0. Outputs drop immediately, with no clock edge needed. This includes reset asserted mid-RUN.
- Grant latency: req sampled high at edge k in IDLE → motor high immediately after edge k.
- Run length:
  - Request released early: a granted motor is high for max(MIN_ON, cycles until req is sampled low) cycles.
  - Under continuous contention: exactly MAX_ON cycles.
- Motor-to-motor gap: both motors low for DEAD_T cycles in DEAD, plus 1 cycle in IDLE, giving DEAD_T+1 cycles minimum. After reset or after leaving FAULT, no dead time precedes the first grant.
- Alarm latency: alarm sampled at edge k → m1 = m2 = 0 and falha = 1 after edge k.
- Fault exit: on the clear edge falha falls. The next grant occurs one edge later, at the earliest.
- Simultaneous req1 and req2 rising in the same cycle in IDLE: resolved by vez; the loser waits.

## Test plan
- Reset: rst_n=0 with req1=req2=1 → m1=m2=falha=vez=0. Release reset; m1=1 after the first edge.
- Minimum on time (MIN_ON=8): req1 high for 3 cycles, then low → m1 high exactly 8 cycles, then DEAD for 4 cycles, IDLE, and m2 stays 0 throughout.
- Contention (MAX_ON=64, DEAD_T=4): req1=req2=1 held from reset → repeating pattern of m1 high 64 cycles, both low 5 cycles, m2 high 64 cycles, both low 5 cycles. vez toggles at each grant.
- Fault:
  - alarme1 pulses during RUN2, cycle 10 → m2=0 and falha=1 next edge.
  - clr_falha with alarme1 still high → falha stays 1.
  - alarme1 low, then clr_falha → falha=0.
  - With req1=1, m1=1 one edge later.
- Async reset mid-RUN1 at cnt=20 → m1 falls with no clock edge. After release, IDLE and vez=0.
- Random req/alarm stimulus for 10k cycles, checking at all times:
  - m1&m2 is never high
  - every motor on-run lasts ≥MIN_ON cycles, unless cut by an alarm or reset
  - every m1↔m2 handover gap is ≥DEAD_T+1 cycles
